// File: rtl/io_spi_master.sv
// io_spi_master: memory-mapped 8-bit SPI master for the FemtoRV32 one-hot IO page.
// Programmable SCK divider, CPOL/CPHA modes 0..3, software chip select.
// Optional build macro: IO_SPI_MASTER_IRQ_EN (adds CTRL[13] ien and the irq pulse).
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   sel_dat, sel_ctl     DATA / CTRL register selects
//   wr, rd               single-cycle write / read strobes
//   wdata                write data
//   rdata                registered read data, valid the cycle after rd
//   spi_sck, spi_mosi    SPI clock and data out
//   spi_miso             SPI data in (pin level)
//   spi_cs_n             chip select, active low, software controlled
//   irq                  transfer-done pulse (tied low unless the macro is defined)
module io_spi_master #(
    parameter logic [7:0] DIV_RESET  = 8'd5,
    parameter logic [1:0] MODE_RESET = 2'b00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_dat,
    input  logic        sel_ctl,
    input  logic        wr,
    input  logic        rd,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LEAD, TRAIL, DONE} state_t;

    state_t      state, state_d;
    logic [7:0]  div, div_d;
    logic [1:0]  mode, mode_d;
    logic        ovr, ovr_d;
    logic        busy, busy_d;
    logic [7:0]  rx, rx_d;
    logic [7:0]  shifter, shifter_d;
    logic [7:0]  cnt, cnt_d;
    logic [2:0]  bit_cnt, bit_cnt_d;
    logic        sck_d, mosi_d, cs_n_d, irq_d;
    logic [31:0] rdata_d;
    logic [31:0] ctl_val, dat_val;
    logic        expire;
    logic        ien_bit;

`ifdef IO_SPI_MASTER_IRQ_EN
    logic ien, ien_d;
    assign ien_bit = ien;
    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:14], wdata[12]};
`else
    assign ien_bit = 1'b0;
    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:12]};
`endif

    assign ctl_val = {18'b0, ien_bit, busy, ovr, ~spi_cs_n, mode, div};
    assign dat_val = {23'b0, busy, rx};
    assign expire  = (cnt == 8'd0);

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div      <= DIV_RESET;
            mode     <= MODE_RESET;
            ovr      <= 1'b0;
            busy     <= 1'b0;
            rx       <= 8'd0;
            shifter  <= 8'd0;
            cnt      <= 8'd0;
            bit_cnt  <= 3'd7;
            spi_sck  <= MODE_RESET[1];
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
            irq      <= 1'b0;
            rdata    <= 32'd0;
`ifdef IO_SPI_MASTER_IRQ_EN
            ien      <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            div      <= div_d;
            mode     <= mode_d;
            ovr      <= ovr_d;
            busy     <= busy_d;
            rx       <= rx_d;
            shifter  <= shifter_d;
            cnt      <= cnt_d;
            bit_cnt  <= bit_cnt_d;
            spi_sck  <= sck_d;
            spi_mosi <= mosi_d;
            spi_cs_n <= cs_n_d;
            irq      <= irq_d;
            rdata    <= rdata_d;
`ifdef IO_SPI_MASTER_IRQ_EN
            ien      <= ien_d;
`endif
        end
    end

    // Register access, next-state and shift logic
    always_comb begin
        state_d   = state;
        div_d     = div;
        mode_d    = mode;
        ovr_d     = ovr;
        busy_d    = busy;
        rx_d      = rx;
        shifter_d = shifter;
        cnt_d     = cnt;
        bit_cnt_d = bit_cnt;
        sck_d     = spi_sck;
        mosi_d    = spi_mosi;
        cs_n_d    = spi_cs_n;
        irq_d     = 1'b0;
        rdata_d   = rdata;
`ifdef IO_SPI_MASTER_IRQ_EN
        ien_d     = ien;
`endif

        if (rd) begin
            rdata_d = (sel_dat ? dat_val : 32'd0) | (sel_ctl ? ctl_val : 32'd0);
        end

        // cs and the ovr clear always apply; timing fields are frozen while busy
        if (sel_ctl && wr) begin
            cs_n_d = ~wdata[10];
            if (!busy) begin
                div_d  = wdata[7:0];
                mode_d = wdata[9:8];
            end
            if (wdata[11]) ovr_d = 1'b0;
`ifdef IO_SPI_MASTER_IRQ_EN
            ien_d = wdata[13];
`endif
        end

        if (sel_dat && wr && busy) ovr_d = 1'b1;

        case (state)
            IDLE: begin
                sck_d = mode_d[1];
                if (sel_dat && wr) begin
                    shifter_d = wdata[7:0];
                    busy_d    = 1'b1;
                    cnt_d     = div_d;
                    bit_cnt_d = 3'd7;
                    state_d   = LEAD;
                    if (!mode_d[0]) mosi_d = wdata[7];
                end
            end
            LEAD: begin
                if (expire) begin
                    cnt_d = div;
                    sck_d = ~mode[1];
                    if (!mode[0]) shifter_d = {shifter[6:0], spi_miso};
                    else          mosi_d    = shifter[7];
                    state_d = TRAIL;
                end else begin
                    cnt_d = 8'(cnt - 8'd1);
                end
            end
            TRAIL: begin
                if (expire) begin
                    cnt_d = div;
                    sck_d = mode[1];
                    // CPHA=0 already shifted on the leading edge, so shifter[7] is the next bit
                    if (mode[0])                 shifter_d = {shifter[6:0], spi_miso};
                    else if (bit_cnt != 3'd0)    mosi_d    = shifter[7];
                    if (bit_cnt == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = 3'(bit_cnt - 3'd1);
                        state_d   = LEAD;
                    end
                end else begin
                    cnt_d = 8'(cnt - 8'd1);
                end
            end
            DONE: begin
                rx_d    = shifter;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef IO_SPI_MASTER_IRQ_EN
        // Registered so the pulse coincides with the DONE cycle
        irq_d = (state_d == DONE) && ien;
`endif
    end

endmodule

// File: tb/tb_io_spi_master.sv
// Directed self-checking bench for io_spi_master: loopback and slave-model transfers.
module tb_io_spi_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel_dat = 1'b0, sel_ctl = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        spi_sck, spi_mosi, spi_miso, spi_cs_n, irq;

    int n_chk = 0;
    int n_fail = 0;

    // Slave model: loopback, or shifts s_tx out per CPOL/CPHA
    logic       loopback = 1'b1;
    logic       s_act = 1'b0;
    logic       s_bit = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0;
    logic [7:0] s_tx = 8'd0;
    int         s_idx = 0;

    // Capture of MOSI on SCK rising edges
    logic       rec = 1'b0;
    logic [7:0] mosi_cap = 8'd0;
    int         n_rise = 0;
    time        t_rise[2];

    int irq_cnt = 0;

    assign spi_miso = loopback ? spi_mosi : s_bit;

    io_spi_master dut (
        .clk(clk), .reset(reset), .sel_dat(sel_dat), .sel_ctl(sel_ctl),
        .wr(wr), .rd(rd), .wdata(wdata), .rdata(rdata),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(spi_sck) begin
        if (s_act) begin
            if (!cpha && (spi_sck == cpol)) begin
                s_idx = s_idx + 1;
                if (s_idx < 8) s_bit = s_tx[3'(7 - s_idx)];
            end
            if (cpha && (spi_sck != cpol) && (s_idx < 8)) begin
                s_bit = s_tx[3'(7 - s_idx)];
                s_idx = s_idx + 1;
            end
        end
    end

    always @(posedge spi_sck) begin
        if (rec) begin
            mosi_cap = {mosi_cap[6:0], spi_mosi};
            if (n_rise < 2) t_rise[n_rise] = $time;
            n_rise = n_rise + 1;
        end
    end

    always @(negedge clk) if (irq === 1'b1) irq_cnt = irq_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr_reg(input logic ctl, input logic [31:0] d);
        @(negedge clk);
        sel_ctl = ctl; sel_dat = !ctl; wr = 1'b1; wdata = d;
        @(negedge clk);
        wr = 1'b0; sel_ctl = 1'b0; sel_dat = 1'b0;
    endtask

    task automatic rd_reg(input logic ctl, output logic [31:0] v);
        @(negedge clk);
        sel_ctl = ctl; sel_dat = !ctl; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0; sel_ctl = 1'b0; sel_dat = 1'b0;
        v = rdata;
    endtask

    // Polls CTRL every cycle; n = cycles seen busy before it reads 0
    task automatic wait_idle(input string tag, output int n);
        logic done;
        n = 0;
        done = 1'b0;
        sel_ctl = 1'b1; rd = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (rdata[12]) n = n + 1;
            else           done = 1'b1;
        end
        rd = 1'b0; sel_ctl = 1'b0;
        check({tag, "_idle"}, 32'(done), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int          n;

        // Reset state
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_sck", 32'(spi_sck), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        rd_reg(1'b1, v);
        check("rst_ctl", v, 32'h0000_0005);

        // Mode 0, div 5, loopback of 0xA5
        wr_reg(1'b1, 32'h405);
        check("cs_on", 32'(spi_cs_n), 32'd0);
        rec = 1'b1; n_rise = 0;
        wr_reg(1'b0, 32'hA5);
        wait_idle("a5", n);
        rec = 1'b0;
        check("a5_busy_cycles", 32'(n), 32'd97);
        check("a5_mosi_bits", 32'(mosi_cap), 32'hA5);
        check("a5_rises", 32'(n_rise), 32'd8);
        check("a5_sck_period", 32'((t_rise[1] - t_rise[0]) / 10), 32'd12);
        rd_reg(1'b0, v);
        check("a5_rx", v, 32'h0A5);

        // All four modes at div 0 against a slave returning 0x3C
        loopback = 1'b0;
        for (int m = 0; m < 4; m++) begin
            cpol = m[1]; cpha = m[0];
            wr_reg(1'b1, 32'h400 | (32'(m) << 8));
            check($sformatf("m%0d_idle_sck", m), 32'(spi_sck), 32'(cpol));
            s_tx = 8'h3C; s_idx = 0; s_bit = s_tx[7]; s_act = 1'b1;
            wr_reg(1'b0, 32'h00);
            wait_idle($sformatf("m%0d", m), n);
            s_act = 1'b0;
            check($sformatf("m%0d_busy_cycles", m), 32'(n), 32'd17);
            check($sformatf("m%0d_sck_after", m), 32'(spi_sck), 32'(cpol));
            rd_reg(1'b0, v);
            check($sformatf("m%0d_rx", m), v, 32'h03C);
        end
        loopback = 1'b1;

        // DATA write while busy sets ovr and is dropped
        wr_reg(1'b1, 32'h405);
        wr_reg(1'b0, 32'h12);
        wr_reg(1'b0, 32'h34);
        rd_reg(1'b1, v);
        check("ovr_set", v, 32'h1C05);
        wait_idle("ovr", n);
        rd_reg(1'b0, v);
        check("ovr_rx", v, 32'h012);
        wr_reg(1'b1, 32'hC05);
        rd_reg(1'b1, v);
        check("ovr_clr", v, 32'h405);

        // div write mid-transfer ignored; cs write takes effect next cycle
        wr_reg(1'b0, 32'h5A);
        wr_reg(1'b1, 32'h000);
        check("mid_cs_off", 32'(spi_cs_n), 32'd1);
        wait_idle("mid", n);
        check("mid_busy_cycles", 32'(n), 32'd95);
        rd_reg(1'b1, v);
        check("mid_ctl", v, 32'h005);
        rd_reg(1'b0, v);
        check("mid_rx", v, 32'h05A);

`ifdef IO_SPI_MASTER_IRQ_EN
        wr_reg(1'b1, 32'h2405);
        rd_reg(1'b1, v);
        check("ien_rd", v, 32'h2405);
        irq_cnt = 0;
        wr_reg(1'b0, 32'h77);
        wait_idle("irq", n);
        repeat (3) @(negedge clk);
        check("irq_pulses", 32'(irq_cnt), 32'd1);
`else
        check("irq_never", 32'(irq_cnt), 32'd0);
`endif

        // Asynchronous reset mid-transfer
        wr_reg(1'b1, 32'h405);
        wr_reg(1'b0, 32'hC3);
        rd_reg(1'b1, v);
        check("pre_rst_ctl", v, 32'h1405);
        repeat (40) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_rdata", rdata, 32'h0);
        check("arst_cs_n", 32'(spi_cs_n), 32'd1);
        check("arst_sck", 32'(spi_sck), 32'd0);
        check("arst_mosi", 32'(spi_mosi), 32'd0);
        check("arst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_reg(1'b1, v);
        check("arst_ctl", v, 32'h005);
        rd_reg(1'b0, v);
        check("arst_rx", v, 32'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
